pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Instruction-fetch and program-counter stage feeding the opcode decoder/control unit of the single-cycle CPU. Holds the PC and fetches from instruction memory via a read/busywait handshake. Presents the latched 32-bit instruction, whose [31:24] field drives the control unit's OPCODE. Computes the next PC from the decoder's BEQSIGNAL, BNESIGNAL and JSIGNAL and the ALU ZERO flag.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset
OFFSET_MSB, 23, MSB of the 8-bit branch/jump word-offset field in the instruction (field is [OFFSET_MSB:OFFSET_MSB-7])

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
BEQSIGNAL  input  1  from control unit; branch if ZERO
BNESIGNAL  input  1  from control unit; branch if not ZERO
JSIGNAL  input  1  from control unit; unconditional jump
ZERO  input  1  ALU zero flag for the current instruction
D_BUSYWAIT  input  1  data-memory stall; holds the EXEC state
I_READDATA  input  32  instruction word from instruction memory
I_BUSYWAIT  input  1  instruction memory busy; I_READDATA invalid while high
I_READ  output  1  instruction-memory read request
I_ADDRESS  output  32  instruction-memory byte address (= PC)
PC  output  32  current program counter
INSTRUCTION  output  32  latched instruction; [31:24] is OPCODE to control unit
INSTR_VALID  output  1  high in EXEC; datapath gates register-file writes with it
STALL  output  1  high whenever the stage is not advancing

Behaviour:
- Reset (RESET low, async): PC=RESET_PC, INSTRUCTION=32'h0, state=FETCH, INSTR_VALID=0, I_READ=0 while RESET is low. Reset mid-fetch or mid-EXEC abandons the instruction immediately. No PC update occurs.
- States: FETCH, EXEC.
- FETCH:
  - I_READ=1 (RESET high), I_ADDRESS=PC, INSTR_VALID=0, STALL=1.
  - Rising edge with I_BUSYWAIT=0: INSTRUCTION<=I_READDATA; go to EXEC.
  - Rising edge with I_BUSYWAIT=1: stay in FETCH; INSTRUCTION is held.
- EXEC:
  - I_READ=0, INSTR_VALID=1.
  - STALL=D_BUSYWAIT.
  - Rising edge with D_BUSYWAIT=0: PC<=NEXT_PC; go to FETCH.
  - Rising edge with D_BUSYWAIT=1: hold PC, INSTRUCTION and state.
- NEXT_PC (combinational):
  - PC4 = PC+4.
  - OFF = INSTRUCTION[OFFSET_MSB:OFFSET_MSB-7], sign-extended to 32 bits and shifted left 2.
  - TAKEN = JSIGNAL | (BEQSIGNAL & ZERO) | (BNESIGNAL & ~ZERO).
  - NEXT_PC = TAKEN ? PC4+OFF : PC4.
- Arithmetic: all 32-bit unsigned modulo 2^32. PC 32'hFFFFFFFC +4 wraps to 0. A negative offset below 0 wraps.
- Offset 8'hFF gives target = PC, a self-loop that is legal.
- Simultaneous control signals: any true term makes TAKEN=1; all taken paths share one target. Signal values are sampled only at the EXEC-exit edge.
- Best-case throughput: 2 cycles per instruction (I_BUSYWAIT low in the first FETCH cycle).
- X on I_READDATA during busywait must never reach INSTRUCTION.

Test Plan:
- Reset, then I_BUSYWAIT=0, I_READDATA=32'h07040009 → I_ADDRESS=0 in the first cycle; next edge INSTRUCTION=32'h07040009, INSTR_VALID=1; following edge PC=4.
- Memory stalls 3 cycles (I_BUSYWAIT=1) at PC=8 → I_READ stays 1, STALL=1, INSTRUCTION unchanged for 3 edges; latched on the 4th edge.
- beq at PC=12 with offset 8'h02: ZERO=1 → PC=24. Repeat with ZERO=0 → PC=16. bne with ZERO=0 and offset 8'hFE → PC=8.
- j with offset 8'hFF at PC=20 → PC=20 (self-loop); j with offset 8'h80 at PC=0 → PC=32'hFFFFFE04 (wrap).
- D_BUSYWAIT=1 for 2 cycles in EXEC → PC, INSTRUCTION and INSTR_VALID=1 held; advance on the edge where D_BUSYWAIT=0.
- RESET pulsed low mid-FETCH with I_BUSYWAIT=1 → I_READ=0 immediately, PC=0, INSTRUCTION=0, INSTR_VALID=0; fetch restarts at 0 after release.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage: two-state FETCH/EXEC sequencer with
// branch/jump next-PC computation from the decoder's control signals and ALU ZERO.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned OFFSET_MSB = 23
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BEQSIGNAL,
  input  logic        BNESIGNAL,
  input  logic        JSIGNAL,
  input  logic        ZERO,
  input  logic        D_BUSYWAIT,
  input  logic [31:0] I_READDATA,
  input  logic        I_BUSYWAIT,
  output logic        I_READ,
  output logic [31:0] I_ADDRESS,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        INSTR_VALID,
  output logic        STALL
);

  typedef enum logic {StFetch, StExec} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  logic [7:0]  off8;
  logic [31:0] off;
  logic [31:0] pc4;
  logic        taken;
  logic [31:0] next_pc;

  // Word offset: sign-extend the 8-bit field and scale to bytes.
  always_comb begin
    off8    = instr_q[OFFSET_MSB -: 8];
    off     = {{22{off8[7]}}, off8, 2'b00};
    pc4     = pc_q + 32'd4;
    taken   = JSIGNAL | (BEQSIGNAL & ZERO) | (BNESIGNAL & ~ZERO);
    next_pc = taken ? (pc4 + off) : pc4;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      unique case (state_q)
        StFetch: begin
          // Only latch when memory is ready so X during busywait never lands here.
          if (!I_BUSYWAIT) begin
            instr_q <= I_READDATA;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (!D_BUSYWAIT) begin
            pc_q    <= next_pc;
            state_q <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    I_READ      = RESET && (state_q == StFetch);
    I_ADDRESS   = pc_q;
    PC          = pc_q;
    INSTRUCTION = instr_q;
    INSTR_VALID = (state_q == StExec);
    STALL       = (state_q == StFetch) || D_BUSYWAIT;
  end

endmodule
